ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 16-bit pipeline: consumes the ID/EX register outputs, applies MEM/WB forwarding, runs the ALU, resolves jumps and branches, and registers the results into the EX/MEM outputs. A 16-cycle shift-add multiplier stalls the front end through `Busy`, which drives the upstream `Pause`. All outputs are registered except `Busy`.

## Interface
- No parameters; widths fixed: data 16, register index 4, AluOp 4, flags 2.
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- RegWrite1, MemotoReg1, MemWrite1, MemRead1  in  1 each  control bits from ID/EX.
- AluOp1  in  4  operation code.
- PcAddr1  in  16  PC of the instruction.
- RegData11, RegData21  in  16  operands A, B from register file.
- Flag1  in  2  current flags {N,Z}.
- RegWriteIndex1, RegReadIndex11, RegReadIndex21  in  4  destination and source indices.
- InsJ1  in  1  unconditional jump.
- InsB1  in  2  branch type.
- AluSrc1  in  1  1 = operand B is Dest1.
- Dest1  in  16  immediate / branch offset / jump target.
- MemFwdEn, WbFwdEn  in  1  forward source valid.
- MemFwdIndex, WbFwdIndex  in  4  forward destination index.
- MemFwdData, WbFwdData  in  16  forward value.
- RegWrite2, MemotoReg2, MemWrite2, MemRead2  out  1  registered control bits.
- AluResult2  out  16  registered result.
- StoreData2  out  16  forwarded operand B (register value, never the immediate).
- RegWriteIndex2  out  4  registered destination.
- Flag2  out  2  registered flags {N,Z}.
- BranchTaken  out  1  one-cycle redirect pulse; also the upstream flush.
- BranchTarget  out  16  redirect PC.
- Busy  out  1  combinational multiply stall.

## Operation
- Forwarding per source: MEM match (`En` and index equal) beats WB match, which beats the register data. Index 0 is forwarded like any other index.
- Operand B is Dest1 when AluSrc1=1; otherwise it is the forwarded RegData21.
- AluOp encoding:
  - 0: no_alu_op, result = B.
  - 1: ADD. 2: SUB (A−B). 3: AND. 4: OR. 5: XOR. 6: NOT A.
  - 7: SLL A by B[3:0]. 8: SRL. 9: SRA.
  - 10: MUL, low 16 bits of A×B.
  - 11: CMP, computes A−B and updates flags only; RegWrite2 forced 0.
  - 12–15: result 0.
- Arithmetic wraps modulo 2^16.
- Flags are updated for ADD, SUB, CMP and MUL: Z = (result==0), N = result[15]. For all other ops Flag2 = Flag1.
- Branches are taken on Flag1, the flags entering the stage:
  - InsB: 00 = NB. 01 = BZ, taken if Z. 10 = BNZ, taken if !Z. 11 = BN, taken if N.
  - Branch target = PcAddr1 + Dest1, wrapping.
- InsJ1=1 is always taken with target Dest1. InsJ1 has priority over InsB1.
- MUL FSM, states IDLE and MUL:
  - IDLE→MUL when AluOp1=10. This latches A, B, destination and control, and clears acc and cnt.
  - In MUL, each cycle: if B[cnt], acc += A<<cnt; cnt++.
  - After cnt=15 the FSM returns to IDLE and registers acc, flags and control onto the outputs.
- Busy = (state==IDLE && AluOp1==10) || state==MUL.
- While in MUL, inputs are ignored (upstream supplies bubbles) and the outputs hold a bubble: all control 0, result 0.

## Timing
- Reset: every registered output is 0, including BranchTaken, BranchTarget and Flag2. The FSM is IDLE, cnt=0, and Busy follows its equation.
- Single-cycle ops: latency 1; results appear on the edge after the inputs are presented.
- MUL:
  - Acceptance edge: the FSM enters MUL and the outputs show a bubble.
  - The product appears on the 17th rising edge after acceptance.
  - Busy is high for the 17 cycles from acceptance up to, but not including, that edge.
- BranchTaken is high for exactly one cycle per taken branch or jump. A branch inside the MUL shadow cannot occur because the inputs are bubbles.
- Reset asserted mid-multiply aborts immediately: IDLE, outputs 0, no partial product is emitted.
- Simultaneous MEM and WB match on the same index: MEM data wins.

## Configuration
- `EX_MUL_EN` defined: the MUL FSM is built as above.
- Not defined:
  - Op 10 behaves as single-cycle with result 0 and flags Z=1, N=0.
  - Busy is tied to 0.
  - No FSM registers exist.

## Test plan
- ADD, A=0x7FFF, B=0x0001 → AluResult2=0x8000, Flag2={N=1,Z=0} one cycle later; SUB 5−5 → 0x0000, Z=1.
- RegReadIndex11=3 with MemFwd (index 3, 0x1111) and WbFwd (index 3, 0x2222) both valid, ADD immediate Dest1=1 → AluResult2=0x1112.
- BZ with Flag1=01, PcAddr1=0x0010, Dest1=0xFFF0 → BranchTaken=1 for one cycle, BranchTarget=0x0000; the same with Flag1=00 → BranchTaken stays 0.
- MUL, A=0x0123, B=0x0045 → Busy high 17 cycles, bubble outputs during the stall, then AluResult2=0x4E6F and RegWrite2=1 for one cycle.
- Rst pulsed low at multiply cycle 8 → all outputs 0 immediately; the next ADD completes normally with latency 1.
- Build without `EX_MUL_EN`: MUL → result 0, Busy never 1.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline (forwarding, ALU, branch resolution, EX/MEM register).
// Define EX_MUL_EN to build the 16-cycle shift-add multiplier; otherwise op 10 is a single-cycle zero.
module ex_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWrite1,
  input  logic        MemotoReg1,
  input  logic        MemWrite1,
  input  logic        MemRead1,
  input  logic [3:0]  AluOp1,
  input  logic [15:0] PcAddr1,
  input  logic [15:0] RegData11,
  input  logic [15:0] RegData21,
  input  logic [1:0]  Flag1,
  input  logic [3:0]  RegWriteIndex1,
  input  logic [3:0]  RegReadIndex11,
  input  logic [3:0]  RegReadIndex21,
  input  logic        InsJ1,
  input  logic [1:0]  InsB1,
  input  logic        AluSrc1,
  input  logic [15:0] Dest1,
  input  logic        MemFwdEn,
  input  logic        WbFwdEn,
  input  logic [3:0]  MemFwdIndex,
  input  logic [3:0]  WbFwdIndex,
  input  logic [15:0] MemFwdData,
  input  logic [15:0] WbFwdData,
  output logic        RegWrite2,
  output logic        MemotoReg2,
  output logic        MemWrite2,
  output logic        MemRead2,
  output logic [15:0] AluResult2,
  output logic [15:0] StoreData2,
  output logic [3:0]  RegWriteIndex2,
  output logic [1:0]  Flag2,
  output logic        BranchTaken,
  output logic [15:0] BranchTarget,
  output logic        Busy
);
  logic [15:0] w_op_a, w_fwd_b, w_op_b, w_sum, w_diff, w_result, w_target;
  logic [1:0]  w_flags;
  logic        w_reg_write, w_taken;
  logic [3:0]  w_n_ctl, w_n_idx;
  logic [15:0] w_n_result, w_n_sd, w_n_target;
  logic [1:0]  w_n_flags;
  logic        w_n_taken;

  assign w_op_b = AluSrc1 ? Dest1 : w_fwd_b;
  assign w_sum  = w_op_a + w_op_b;
  assign w_diff = w_op_a - w_op_b;

  // operand forwarding: MEM beats WB beats register file
  always_comb begin
    if (MemFwdEn && (MemFwdIndex == RegReadIndex11)) w_op_a = MemFwdData;
    else if (WbFwdEn && (WbFwdIndex == RegReadIndex11)) w_op_a = WbFwdData;
    else w_op_a = RegData11;
    if (MemFwdEn && (MemFwdIndex == RegReadIndex21)) w_fwd_b = MemFwdData;
    else if (WbFwdEn && (WbFwdIndex == RegReadIndex21)) w_fwd_b = WbFwdData;
    else w_fwd_b = RegData21;
  end

  always_comb begin
    w_result    = 16'h0000;
    w_flags     = Flag1;
    w_reg_write = RegWrite1;
    case (AluOp1)
      4'd0:  w_result = w_op_b;
      4'd1:  begin w_result = w_sum;  w_flags = {w_sum[15], (w_sum == 16'h0000)}; end
      4'd2:  begin w_result = w_diff; w_flags = {w_diff[15], (w_diff == 16'h0000)}; end
      4'd3:  w_result = w_op_a & w_op_b;
      4'd4:  w_result = w_op_a | w_op_b;
      4'd5:  w_result = w_op_a ^ w_op_b;
      4'd6:  w_result = ~w_op_a;
      4'd7:  w_result = w_op_a << w_op_b[3:0];
      4'd8:  w_result = w_op_a >> w_op_b[3:0];
      4'd9:  w_result = $signed(w_op_a) >>> w_op_b[3:0];
      4'd10: begin w_result = 16'h0000; w_flags = 2'b01; end
      4'd11: begin w_result = w_diff; w_flags = {w_diff[15], (w_diff == 16'h0000)}; w_reg_write = 1'b0; end
      default: w_result = 16'h0000;
    endcase
  end

  // flags used here are the ones entering the stage, not the ALU's
  always_comb begin
    w_target = PcAddr1 + Dest1;
    w_taken  = 1'b0;
    if (InsJ1) begin
      w_taken  = 1'b1;
      w_target = Dest1;
    end else begin
      case (InsB1)
        2'b01:   w_taken = Flag1[0];
        2'b10:   w_taken = ~Flag1[0];
        2'b11:   w_taken = Flag1[1];
        default: w_taken = 1'b0;
      endcase
    end
  end

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_mul_a, r_mul_b, r_acc, r_mul_sd;
  logic [3:0]  r_mul_idx, r_mul_ctl;
  logic        w_mul_done;

  assign Busy       = ((r_state == S_IDLE) && (AluOp1 == 4'd10)) || (r_state == S_MUL);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == 5'd16);

  // cnt 0..15 accumulate one bit each; cnt 16 is the write-back cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_acc     <= 16'h0000;
      r_mul_a   <= 16'h0000;
      r_mul_b   <= 16'h0000;
      r_mul_sd  <= 16'h0000;
      r_mul_idx <= 4'd0;
      r_mul_ctl <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (AluOp1 == 4'd10) begin
            r_state   <= S_MUL;
            r_mul_a   <= w_op_a;
            r_mul_b   <= w_op_b;
            r_mul_sd  <= w_fwd_b;
            r_mul_idx <= RegWriteIndex1;
            r_mul_ctl <= {RegWrite1, MemotoReg1, MemWrite1, MemRead1};
            r_acc     <= 16'h0000;
            r_cnt     <= 5'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (r_cnt == 5'd16) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            if (r_mul_b[r_cnt[3:0]]) r_acc <= r_acc + (r_mul_a << r_cnt[3:0]);
            else r_acc <= r_acc;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign Busy = 1'b0;
`endif

  always_comb begin
    w_n_ctl    = {w_reg_write, MemotoReg1, MemWrite1, MemRead1};
    w_n_result = w_result;
    w_n_sd     = w_fwd_b;
    w_n_idx    = RegWriteIndex1;
    w_n_flags  = w_flags;
    w_n_taken  = w_taken;
    w_n_target = w_taken ? w_target : 16'h0000;
`ifdef EX_MUL_EN
    if (w_mul_done) begin
      w_n_ctl    = r_mul_ctl;
      w_n_result = r_acc;
      w_n_sd     = r_mul_sd;
      w_n_idx    = r_mul_idx;
      w_n_flags  = {r_acc[15], (r_acc == 16'h0000)};
      w_n_taken  = 1'b0;
      w_n_target = 16'h0000;
    end else if (Busy) begin
      w_n_ctl    = 4'd0;
      w_n_result = 16'h0000;
      w_n_sd     = 16'h0000;
      w_n_idx    = 4'd0;
      w_n_flags  = Flag2;
      w_n_taken  = 1'b0;
      w_n_target = 16'h0000;
    end else begin
      w_n_taken = w_taken;
    end
`endif
  end

  // EX/MEM output register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      {RegWrite2, MemotoReg2, MemWrite2, MemRead2} <= 4'd0;
      AluResult2     <= 16'h0000;
      StoreData2     <= 16'h0000;
      RegWriteIndex2 <= 4'd0;
      Flag2          <= 2'b00;
      BranchTaken    <= 1'b0;
      BranchTarget   <= 16'h0000;
    end else begin
      {RegWrite2, MemotoReg2, MemWrite2, MemRead2} <= w_n_ctl;
      AluResult2     <= w_n_result;
      StoreData2     <= w_n_sd;
      RegWriteIndex2 <= w_n_idx;
      Flag2          <= w_n_flags;
      BranchTaken    <= w_n_taken;
      BranchTarget   <= w_n_target;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; expectations come from an independent model of the stage.
module tb_ex_stage;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        RegWrite1, MemotoReg1, MemWrite1, MemRead1;
  logic [3:0]  AluOp1;
  logic [15:0] PcAddr1, RegData11, RegData21, Dest1;
  logic [1:0]  Flag1, InsB1;
  logic [3:0]  RegWriteIndex1, RegReadIndex11, RegReadIndex21;
  logic        InsJ1, AluSrc1, MemFwdEn, WbFwdEn;
  logic [3:0]  MemFwdIndex, WbFwdIndex;
  logic [15:0] MemFwdData, WbFwdData;
  logic        RegWrite2, MemotoReg2, MemWrite2, MemRead2;
  logic [15:0] AluResult2, StoreData2, BranchTarget;
  logic [3:0]  RegWriteIndex2;
  logic [1:0]  Flag2;
  logic        BranchTaken, Busy;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [15:0] res;
    logic [15:0] sd;
    logic [3:0]  idx;
    logic [1:0]  flg;
    logic        bt;
    logic [15:0] btgt;
  } exp_t;

  exp_t sb[$];
  exp_t mul_exp;
  int   mul_rem = 0;
  logic [1:0] last_flg = 2'b00;
  logic exp_busy;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt;

  ex_stage dut (
    .Clk(Clk), .Rst(Rst),
    .RegWrite1(RegWrite1), .MemotoReg1(MemotoReg1), .MemWrite1(MemWrite1), .MemRead1(MemRead1),
    .AluOp1(AluOp1), .PcAddr1(PcAddr1), .RegData11(RegData11), .RegData21(RegData21),
    .Flag1(Flag1), .RegWriteIndex1(RegWriteIndex1), .RegReadIndex11(RegReadIndex11),
    .RegReadIndex21(RegReadIndex21), .InsJ1(InsJ1), .InsB1(InsB1), .AluSrc1(AluSrc1), .Dest1(Dest1),
    .MemFwdEn(MemFwdEn), .WbFwdEn(WbFwdEn), .MemFwdIndex(MemFwdIndex), .WbFwdIndex(WbFwdIndex),
    .MemFwdData(MemFwdData), .WbFwdData(WbFwdData),
    .RegWrite2(RegWrite2), .MemotoReg2(MemotoReg2), .MemWrite2(MemWrite2), .MemRead2(MemRead2),
    .AluResult2(AluResult2), .StoreData2(StoreData2), .RegWriteIndex2(RegWriteIndex2),
    .Flag2(Flag2), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] idx, input logic [15:0] rd);
    if (MemFwdEn && MemFwdIndex == idx) return MemFwdData;
    if (WbFwdEn && WbFwdIndex == idx) return WbFwdData;
    return rd;
  endfunction

  task automatic set_bubble();
    {RegWrite1, MemotoReg1, MemWrite1, MemRead1} = 4'd0;
    AluOp1 = 4'd0; PcAddr1 = 16'h0000; RegData11 = 16'h0000; RegData21 = 16'h0000;
    Flag1 = 2'b00; RegWriteIndex1 = 4'd0; RegReadIndex11 = 4'd0; RegReadIndex21 = 4'd0;
    InsJ1 = 1'b0; InsB1 = 2'b00; AluSrc1 = 1'b0; Dest1 = 16'h0000;
    MemFwdEn = 1'b0; WbFwdEn = 1'b0; MemFwdIndex = 4'd0; WbFwdIndex = 4'd0;
    MemFwdData = 16'h0000; WbFwdData = 16'h0000;
  endtask

  task automatic push_expect();
    exp_t e;
    logic [15:0] fa, fb, b, r;
    logic [1:0] f;
    logic rw;
    e = '0;
    exp_busy = 1'b0;
`ifdef EX_MUL_EN
    if (mul_rem != 0) begin
      exp_busy = 1'b1;
      if (mul_rem == 1) e = mul_exp;
      else e.flg = last_flg;
      mul_rem--;
      sb.push_back(e);
      last_flg = e.flg;
      return;
    end
`endif
    fa = fwd(RegReadIndex11, RegData11);
    fb = fwd(RegReadIndex21, RegData21);
    b  = AluSrc1 ? Dest1 : fb;
    f  = Flag1;
    rw = RegWrite1;
    case (AluOp1)
      4'd0:  r = b;
      4'd1:  begin r = fa + b; f = {r[15], r == 16'h0000}; end
      4'd2:  begin r = fa - b; f = {r[15], r == 16'h0000}; end
      4'd3:  r = fa & b;
      4'd4:  r = fa | b;
      4'd5:  r = fa ^ b;
      4'd6:  r = ~fa;
      4'd7:  r = fa << b[3:0];
      4'd8:  r = fa >> b[3:0];
      4'd9:  r = 16'($signed(fa) >>> b[3:0]);
      4'd10: begin r = 16'h0000; f = 2'b01; end
      4'd11: begin r = fa - b; f = {r[15], r == 16'h0000}; rw = 1'b0; end
      default: r = 16'h0000;
    endcase
`ifdef EX_MUL_EN
    if (AluOp1 == 4'd10) begin
      exp_busy = 1'b1;
      r = fa * b;
      mul_exp = '0;
      mul_exp.ctl = {RegWrite1, MemotoReg1, MemWrite1, MemRead1};
      mul_exp.res = r;
      mul_exp.sd  = fb;
      mul_exp.idx = RegWriteIndex1;
      mul_exp.flg = {r[15], r == 16'h0000};
      mul_rem = 17;
      e.flg = last_flg;
      sb.push_back(e);
      return;
    end
`endif
    e.ctl = {rw, MemotoReg1, MemWrite1, MemRead1};
    e.res = r;
    e.sd  = fb;
    e.idx = RegWriteIndex1;
    e.flg = f;
    if (InsJ1) begin
      e.bt = 1'b1; e.btgt = Dest1;
    end else begin
      case (InsB1)
        2'b01:   e.bt = Flag1[0];
        2'b10:   e.bt = ~Flag1[0];
        2'b11:   e.bt = Flag1[1];
        default: e.bt = 1'b0;
      endcase
      e.btgt = e.bt ? PcAddr1 + Dest1 : 16'h0000;
    end
    sb.push_back(e);
    last_flg = f;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 16'(sb.size()), 16'd1);
      return;
    end
    e = sb.pop_front();
    check_val("ctl", 16'({RegWrite2, MemotoReg2, MemWrite2, MemRead2}), 16'(e.ctl));
    check_val("result", AluResult2, e.res);
    check_val("store", StoreData2, e.sd);
    check_val("wr_idx", 16'(RegWriteIndex2), 16'(e.idx));
    check_val("flags", 16'(Flag2), 16'(e.flg));
    check_val("br_taken", 16'(BranchTaken), 16'(e.bt));
    check_val("br_target", BranchTarget, e.btgt);
  endtask

  // one clock: model the presented inputs, check Busy, then check the registered outputs
  task automatic cycle();
    push_expect();
    #1;
    check_val("busy", 16'(Busy), 16'(exp_busy));
    if (Busy) busy_cnt++;
    @(posedge Clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string tag);
    check_val(tag, 16'({RegWrite2, MemotoReg2, MemWrite2, MemRead2, BranchTaken, Flag2}), 16'd0);
    check_val(tag, AluResult2 | StoreData2 | BranchTarget | 16'(RegWriteIndex2), 16'h0000);
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    set_bubble();
    RegWrite1 = 1'b1; AluOp1 = op; RegData11 = a; RegData21 = b;
    RegReadIndex11 = 4'd1; RegReadIndex21 = 4'd2; RegWriteIndex1 = 4'd5;
  endtask

  initial begin
    set_bubble();
    Rst = 1'b0;
    #12;
    check_zero("reset");
    check_val("reset_busy", 16'(Busy), 16'd0);
    @(negedge Clk);
    Rst = 1'b1;

    alu(4'd1, 16'h7FFF, 16'h0001); cycle();
    check_val("tp_add", AluResult2, 16'h8000);
    check_val("tp_add_flg", 16'(Flag2), 16'd2);
    alu(4'd2, 16'h0005, 16'h0005); cycle();
    check_val("tp_sub", AluResult2, 16'h0000);
    check_val("tp_sub_flg", 16'(Flag2), 16'd1);

    alu(4'd1, 16'h0000, 16'hAAAA);
    RegReadIndex11 = 4'd3; AluSrc1 = 1'b1; Dest1 = 16'h0001;
    MemFwdEn = 1'b1; MemFwdIndex = 4'd3; MemFwdData = 16'h1111;
    WbFwdEn = 1'b1; WbFwdIndex = 4'd3; WbFwdData = 16'h2222;
    cycle();
    check_val("tp_fwd", AluResult2, 16'h1112);
    check_val("tp_store_not_imm", StoreData2, 16'hAAAA);
    alu(4'd5, 16'h0F0F, 16'h0000);
    RegReadIndex11 = 4'd0; RegReadIndex21 = 4'd0;
    WbFwdEn = 1'b1; WbFwdIndex = 4'd0; WbFwdData = 16'h3C3C;
    cycle();
    check_val("tp_fwd_idx0", AluResult2, 16'h0000);

    set_bubble(); InsB1 = 2'b01; Flag1 = 2'b01; PcAddr1 = 16'h0010; Dest1 = 16'hFFF0;
    cycle();
    check_val("tp_bz_taken", 16'(BranchTaken), 16'd1);
    check_val("tp_bz_target", BranchTarget, 16'h0000);
    set_bubble(); cycle();
    check_val("tp_bz_pulse", 16'(BranchTaken), 16'd0);
    set_bubble(); InsB1 = 2'b01; Flag1 = 2'b00; PcAddr1 = 16'h0010; Dest1 = 16'hFFF0;
    cycle();
    check_val("tp_bz_not", 16'(BranchTaken), 16'd0);
    set_bubble(); InsJ1 = 1'b1; InsB1 = 2'b01; Flag1 = 2'b00; PcAddr1 = 16'h1000; Dest1 = 16'h0444;
    cycle();
    check_val("tp_jump_target", BranchTarget, 16'h0444);
    for (int i = 0; i < 4; i++) begin
      set_bubble(); InsB1 = 2'(i); Flag1 = 2'(3 - i); PcAddr1 = 16'h0100; Dest1 = 16'h0020;
      cycle();
    end

    for (int i = 0; i < 60; i++) begin
      {RegWrite1, MemotoReg1, MemWrite1, MemRead1} = 4'($urandom_range(0, 15));
      AluOp1 = 4'(i % 16);
      if (AluOp1 == 4'd10) AluOp1 = 4'(i % 10);
      RegData11 = 16'($urandom); RegData21 = 16'($urandom);
      PcAddr1 = 16'($urandom); Dest1 = 16'($urandom);
      if (i % 5 == 0) RegData21 = RegData11;
      Flag1 = 2'($urandom_range(0, 3)); InsB1 = 2'($urandom_range(0, 3));
      InsJ1 = ($urandom_range(0, 7) == 0);
      AluSrc1 = 1'($urandom_range(0, 1));
      RegWriteIndex1 = 4'($urandom_range(0, 15));
      RegReadIndex11 = 4'($urandom_range(0, 3)); RegReadIndex21 = 4'($urandom_range(0, 3));
      MemFwdEn = 1'($urandom_range(0, 1)); WbFwdEn = 1'($urandom_range(0, 1));
      MemFwdIndex = 4'($urandom_range(0, 3)); WbFwdIndex = 4'($urandom_range(0, 3));
      MemFwdData = 16'($urandom); WbFwdData = 16'($urandom);
      cycle();
    end

    alu(4'd10, 16'h0123, 16'h0045);
    busy_cnt = 0;
    cycle();
`ifdef EX_MUL_EN
    busy_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      set_bubble();
      if (i < 16) begin
        cycle();
      end else begin
        cycle();
        check_val("tp_mul_res", AluResult2, 16'h4E6F);
        check_val("tp_mul_rw", 16'(RegWrite2), 16'd1);
      end
    end
    check_val("tp_mul_busy_len", 16'(busy_cnt), 16'd17);
    set_bubble(); cycle();
    check_val("tp_mul_rw_once", 16'(RegWrite2), 16'd0);

    alu(4'd10, 16'h0123, 16'h0045);
    cycle();
    for (int i = 0; i < 8; i++) begin
      set_bubble(); cycle();
    end
`else
    check_val("tp_nomul_res", AluResult2, 16'h0000);
    check_val("tp_nomul_busy", 16'(busy_cnt), 16'd0);
    alu(4'd1, 16'h1234, 16'h1111); cycle();
`endif
    Rst = 1'b0;
    #1;
    check_zero("tp_rst_mid");
    set_bubble();
    #1;
    check_val("tp_rst_busy", 16'(Busy), 16'd0);
    sb.delete();
    mul_rem = 0;
    last_flg = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    alu(4'd1, 16'h1000, 16'h0234); cycle();
    check_val("tp_after_rst", AluResult2, 16'h1234);
    set_bubble(); cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
